// File: rtl/slot_gpio_pkg.sv
// Shared constants and types for the per-slot GPIO/IRQ stage.
// Register offsets are added to SLOT_INDEX to form each slot's addresses.
package slot_gpio_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

    localparam int OFS_OUT  = 'h00;
    localparam int OFS_IN   = 'h08;
    localparam int OFS_DIR  = 'h10;
    localparam int OFS_PEND = 'h18;
    localparam int OFS_MASK = 'h20;
    localparam int OFS_CLR  = 'h28;
    localparam int OFS_RISE = 'h30;
    localparam int OFS_FALL = 'h38;

    typedef enum logic {
        ARM_PRIME = 1'b0,
        ARM_ARMED = 1'b1
    } arm_state_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser with one-cycle history and per-bit edge detect.
// Ports: sys_clk/sys_rst_n, pad_i, rise_en/fall_en/dir -> sync_q, rise, fall.
module gpio_sync_edge
    import slot_gpio_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] pad_i,
    input  logic [DATA_W-1:0] rise_en,
    input  logic [DATA_W-1:0] fall_en,
    input  logic [DATA_W-1:0] dir,
    output logic [DATA_W-1:0] sync_q,
    output logic [DATA_W-1:0] rise,
    output logic [DATA_W-1:0] fall
);

    logic [DATA_W-1:0] stage_q [SYNC_STAGES];
    logic [DATA_W-1:0] prev_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                stage_q[i] <= '0;
            prev_q <= '0;
        end else begin
            stage_q[0] <= pad_i;
            for (int i = 1; i < SYNC_STAGES; i++)
                stage_q[i] <= stage_q[i-1];
            prev_q <= stage_q[SYNC_STAGES-1];
        end
    end

    assign sync_q = stage_q[SYNC_STAGES-1];

    // Output-configured bits never report edges.
    assign rise = sync_q & ~prev_q & rise_en & ~dir;
    assign fall = ~sync_q & prev_q & fall_en & ~dir;

endmodule

// File: rtl/slot_gpio_irq.sv
// One GPIO slot on the shared register bus: OUT/DIR/IN plus edge IRQs.
// Ports: sys_clk/sys_rst_n, bus_* register bus, pad_i/pad_o/pad_oe, irq.
module slot_gpio_irq
    import slot_gpio_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SLOT_INDEX  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_we,
    input  logic              bus_re,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rvalid,
    input  logic [DATA_W-1:0] pad_i,
    output logic [DATA_W-1:0] pad_o,
    output logic [DATA_W-1:0] pad_oe,
    output logic              irq
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);

    logic [DATA_W-1:0] out_q, dir_q, mask_q;
    logic [DATA_W-1:0] rise_q, fall_q, pend_q;
    logic [DATA_W-1:0] sync_q, rise, fall;
    logic [DATA_W-1:0] clr_mask, edge_set, rd_val;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q, irq_q;

    logic hit_out, hit_in, hit_dir, hit_pend;
    logic hit_mask, hit_clr, hit_rise, hit_fall;
    logic hit_any;

    arm_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              edge_en;

    assign hit_out  = bus_addr == ADDR_W'(OFS_OUT  + SLOT_INDEX);
    assign hit_in   = bus_addr == ADDR_W'(OFS_IN   + SLOT_INDEX);
    assign hit_dir  = bus_addr == ADDR_W'(OFS_DIR  + SLOT_INDEX);
    assign hit_pend = bus_addr == ADDR_W'(OFS_PEND + SLOT_INDEX);
    assign hit_mask = bus_addr == ADDR_W'(OFS_MASK + SLOT_INDEX);
    assign hit_clr  = bus_addr == ADDR_W'(OFS_CLR  + SLOT_INDEX);
    assign hit_rise = bus_addr == ADDR_W'(OFS_RISE + SLOT_INDEX);
    assign hit_fall = bus_addr == ADDR_W'(OFS_FALL + SLOT_INDEX);

    assign hit_any = hit_out | hit_in | hit_dir | hit_pend |
                     hit_mask | hit_clr | hit_rise | hit_fall;

    gpio_sync_edge #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pad_i     (pad_i),
        .rise_en   (rise_q),
        .fall_en   (fall_q),
        .dir       (dir_q),
        .sync_q    (sync_q),
        .rise      (rise),
        .fall      (fall)
    );

    // Arming: hold off edge capture until the synchroniser and history
    // register have been filled with real pad values after reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ARM_PRIME;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == ARM_PRIME)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARM_PRIME: if (cnt_q == CNT_W'(SYNC_STAGES)) state_d = ARM_ARMED;
            ARM_ARMED: state_d = ARM_ARMED;
            default:   state_d = ARM_PRIME;
        endcase
    end

    always_comb begin
        edge_en = (state_q == ARM_ARMED);
    end

    assign clr_mask = (bus_we && hit_clr) ? bus_wdata : '0;
    assign edge_set = (rise | fall) & {DATA_W{edge_en}};

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            hit_out:  rd_val = out_q;
            hit_in:   rd_val = sync_q;
            hit_dir:  rd_val = dir_q;
            hit_pend: rd_val = pend_q;
            hit_mask: rd_val = mask_q;
            hit_rise: rd_val = rise_q;
            hit_fall: rd_val = fall_q;
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_q    <= '0;
            dir_q    <= '0;
            mask_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            pend_q   <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (bus_we && hit_out)  out_q  <= bus_wdata;
            if (bus_we && hit_dir)  dir_q  <= bus_wdata;
            if (bus_we && hit_mask) mask_q <= bus_wdata;
            if (bus_we && hit_rise) rise_q <= bus_wdata;
            if (bus_we && hit_fall) fall_q <= bus_wdata;
            // New edges override a same-cycle clear so none are lost.
            pend_q   <= (pend_q & ~clr_mask) | edge_set;
            irq_q    <= |(pend_q & mask_q);
            rdata_q  <= (bus_re && hit_any) ? rd_val : '0;
            rvalid_q <= bus_re && hit_any;
        end
    end

    assign pad_o      = out_q;
    assign pad_oe     = dir_q;
    assign irq        = irq_q;
    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;

endmodule

// File: tb/tb_slot_gpio_irq.sv
// Self-checking bench for slot_gpio_irq (slot 0, two-stage synchroniser).
// Vector table, directed corner sequences, then random traffic vs a model.
module tb_slot_gpio_irq;

    localparam int DW   = 16;
    localparam int AW   = 8;
    localparam int SLOT = 0;
    localparam int S    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we, re;
    logic [DW-1:0] pad;
    logic [DW-1:0] rdata, pad_o, pad_oe;
    logic          rvalid, irq;

    always #5 clk = ~clk;

    slot_gpio_irq #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .SLOT_INDEX  (SLOT),
        .SYNC_STAGES (S)
    ) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .bus_addr   (addr),
        .bus_wdata  (wdata),
        .bus_we     (we),
        .bus_re     (re),
        .bus_rdata  (rdata),
        .bus_rvalid (rvalid),
        .pad_i      (pad),
        .pad_o      (pad_o),
        .pad_oe     (pad_oe),
        .irq        (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: register file plus a history of sampled pad values.
    logic [DW-1:0] m_out, m_dir, m_mask, m_rise, m_fall, m_pend, m_rdata;
    logic          m_rvalid, m_irq;
    logic [DW-1:0] hist [0:S];
    int            m_edges;

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_mask = '0;
        m_rise = '0; m_fall = '0; m_pend = '0;
        m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0;
        for (int i = 0; i <= S; i++) hist[i] = '0;
        m_edges = 0;
    endtask

    function automatic logic model_hit(logic [AW-1:0] a);
        return (a[7:6] == 2'b00) && (a[2:0] == 3'(SLOT));
    endfunction

    function automatic logic [DW-1:0] model_read(logic [AW-1:0] a);
        case (a[5:3])
            3'd0:    return m_out;
            3'd1:    return hist[S-1];
            3'd2:    return m_dir;
            3'd3:    return m_pend;
            3'd4:    return m_mask;
            3'd6:    return m_rise;
            3'd7:    return m_fall;
            default: return '0;
        endcase
    endfunction

    task automatic model_step();
        logic [DW-1:0] sy, pv, set, clr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_edges++;
        sy  = hist[S-1];
        pv  = hist[S];
        set = ((sy & ~pv & m_rise) | (~sy & pv & m_fall)) & ~m_dir;
        if (m_edges <= S + 1) set = '0;
        m_rvalid = re && model_hit(addr);
        m_rdata  = m_rvalid ? model_read(addr) : '0;
        m_irq    = |(m_pend & m_mask);
        clr = '0;
        if (we && model_hit(addr)) begin
            case (addr[5:3])
                3'd0: m_out  = wdata;
                3'd2: m_dir  = wdata;
                3'd4: m_mask = wdata;
                3'd5: clr    = wdata;
                3'd6: m_rise = wdata;
                3'd7: m_fall = wdata;
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr) | set;
        for (int i = S; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pad;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic bus_write(logic [AW-1:0] a, logic [DW-1:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic bus_read(logic [AW-1:0] a, output logic [DW-1:0] d,
                            output logic v);
        addr = a; re = 1'b1;
        tick();
        d = rdata; v = rvalid;
        re = 1'b0;
    endtask

    task automatic check_model(string tag);
        check({tag, " rdata"},  rdata,         m_rdata);
        check({tag, " rvalid"}, 16'(rvalid),   16'(m_rvalid));
        check({tag, " pad_o"},  pad_o,         m_out);
        check({tag, " pad_oe"}, pad_oe,        m_dir);
        check({tag, " irq"},    16'(irq),      16'(m_irq));
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          we, re;
        logic [DW-1:0] pad;
        logic [DW-1:0] rd;
        logic          rv;
        logic [DW-1:0] po, oe;
        logic          irq;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [DW-1:0] d;
        logic          v;
        int            first;

        addr = '0; wdata = '0; we = 1'b0; re = 1'b0; pad = '0;
        model_reset();

        //                 addr   wdata     we    re    pad       rd        rv    po        oe        irq
        tbl.push_back(vec_t'{8'h10, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0});
        tbl.push_back(vec_t'{8'h10, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0});
        tbl.push_back(vec_t'{8'h10, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h00, 16'hAAAA, 1'b1, 1'b0, 16'hAAAA, 16'h0000, 1'b0, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h00, 16'h0000, 1'b0, 1'b0, 16'hAAAA, 16'h0000, 1'b0, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h00, 16'h0000, 1'b0, 1'b0, 16'hAAAA, 16'h0000, 1'b0, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h08, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 16'hAAAA, 1'b1, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h01, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 16'h0000, 1'b0, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h00, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 16'hAAAA, 1'b1, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h10, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 16'hFFFF, 1'b1, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h20, 16'h1234, 1'b1, 1'b1, 16'hAAAA, 16'h0000, 1'b1, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h20, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 16'h1234, 1'b1, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h28, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 16'h0000, 1'b1, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h20, 16'h0000, 1'b1, 1'b0, 16'hAAAA, 16'h0000, 1'b0, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h40, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 16'h0000, 1'b0, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h08, 16'h5555, 1'b1, 1'b1, 16'hAAAA, 16'hAAAA, 1'b1, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h08, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 16'hAAAA, 1'b1, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h11, 16'h0000, 1'b1, 1'b0, 16'hAAAA, 16'h0000, 1'b0, 16'hAAAA, 16'hFFFF, 1'b0});
        tbl.push_back(vec_t'{8'h10, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 16'hFFFF, 1'b1, 16'hAAAA, 16'hFFFF, 1'b0});

        repeat (3) tick();
        rst_n = 1'b1;
        check("rst pad_oe", pad_oe, 16'h0000);
        check("rst pad_o", pad_o, 16'h0000);
        check("rst irq", 16'(irq), 16'h0000);
        check("rst rdata", rdata, 16'h0000);
        check("rst rvalid", 16'(rvalid), 16'h0000);
        repeat (4) tick();

        foreach (tbl[i]) begin
            addr = tbl[i].addr; wdata = tbl[i].wdata;
            we = tbl[i].we; re = tbl[i].re; pad = tbl[i].pad;
            tick();
            check($sformatf("tbl%0d rdata", i), rdata, tbl[i].rd);
            check($sformatf("tbl%0d rvalid", i), 16'(rvalid), 16'(tbl[i].rv));
            check($sformatf("tbl%0d pad_o", i), pad_o, tbl[i].po);
            check($sformatf("tbl%0d pad_oe", i), pad_oe, tbl[i].oe);
            check($sformatf("tbl%0d irq", i), 16'(irq), 16'(tbl[i].irq));
        end
        we = 1'b0; re = 1'b0;

        // Rising edge on bit 0 -> PEND, irq latency, W1C.
        bus_write(8'h10, 16'h0000);
        pad = 16'h0000;
        repeat (4) tick();
        bus_write(8'h20, 16'h0001);
        bus_write(8'h30, 16'h0001);
        pad = 16'h0001;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (irq && first == 0) first = k;
        end
        check("rise irq latency", 16'(first), 16'(S + 2));
        bus_read(8'h18, d, v);
        check("rise pend", d, 16'h0001);
        bus_write(8'h28, 16'h0001);
        check("clr irq held", 16'(irq), 16'h0001);
        tick();
        check("clr irq low", 16'(irq), 16'h0000);

        // Falling edges latch while masked; unmask raises irq.
        bus_write(8'h30, 16'h0000);
        pad = 16'hFFFF;
        repeat (4) tick();
        bus_write(8'h28, 16'hFFFF);
        bus_write(8'h20, 16'h0000);
        bus_write(8'h38, 16'hFFFF);
        pad = 16'h0000;
        repeat (5) tick();
        bus_read(8'h18, d, v);
        check("fall pend", d, 16'hFFFF);
        check("fall masked irq", 16'(irq), 16'h0000);
        bus_write(8'h20, 16'h8000);
        tick();
        check("unmask irq", 16'(irq), 16'h0001);
        bus_write(8'h28, 16'hFFFF);
        bus_write(8'h38, 16'h0000);
        bus_write(8'h20, 16'h0000);
        repeat (2) tick();
        check("fall cleanup irq", 16'(irq), 16'h0000);

        // New edge lands in the same cycle as a clear of that bit.
        bus_write(8'h30, 16'h0001);
        pad = 16'h0001;
        repeat (4) tick();
        pad = 16'h0000;
        repeat (4) tick();
        pad = 16'h0001;
        tick();
        tick();
        bus_write(8'h28, 16'h0001);
        bus_read(8'h18, d, v);
        check("set beats clr", d, 16'h0001);
        bus_write(8'h28, 16'h0001);
        bus_read(8'h18, d, v);
        check("clr after", d, 16'h0000);

        // Pins high through reset release must not raise PEND.
        pad = 16'hFFFF;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        bus_write(8'h30, 16'hFFFF);
        bus_write(8'h20, 16'hFFFF);
        repeat (6) tick();
        bus_read(8'h18, d, v);
        check("prime pend", d, 16'h0000);
        check("prime irq", 16'(irq), 16'h0000);

        // Reset while irq is high drops it without a clock edge.
        pad = 16'h0000;
        repeat (4) tick();
        pad = 16'hFFFF;
        repeat (5) tick();
        check("pre-reset irq", 16'(irq), 16'h0001);
        rst_n = 1'b0;
        #1;
        check("async rst irq", 16'(irq), 16'h0000);
        model_reset();

        // Random traffic against the model.
        pad = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            logic [2:0] rsel, ssel;
            rsel = 3'($urandom_range(0, 7));
            ssel = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'(SLOT);
            addr = {($urandom_range(0, 15) == 0) ? 2'b01 : 2'b00, rsel, ssel};
            wdata = 16'($urandom);
            we = ($urandom_range(0, 2) == 0);
            re = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 3) == 0) pad = 16'($urandom);
            tick();
            check_model($sformatf("rnd%0d", c));
        end
        we = 1'b0; re = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
